// File: rtl/c6502_bus_pkg.sv
// Shared types and constants for the c6502 bus arbiter and its OAM page-copy DMA engine.
package c6502_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAlign,
        StRd,
        StWr
    } dma_state_e;

    localparam logic [15:0] DmaRegDefault = 16'h4014;
    localparam int unsigned OamLen        = 256;

endpackage

// File: rtl/c6502_oam_dma.sv
// 256-byte page-to-OAM copy engine: one read and one OAM write per byte, frozen while held.
// Optional completion pulse output when C6502_DMA_DONE_EN is defined.
module c6502_oam_dma
    import c6502_bus_pkg::*;
#(
    parameter int unsigned OAM_AW = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              hold_i,
    input  logic              start_i,
    input  logic [7:0]        start_page_i,
    input  logic [7:0]        rd_data_i,
    output logic              busy_o,
    output logic [15:0]       rd_address_o,
    output logic [OAM_AW-1:0] oam_address_o,
    output logic [7:0]        oam_data_o,
    output logic              oam_we_o
`ifdef C6502_DMA_DONE_EN
    ,
    output logic              done_o
`endif
);

    localparam logic [7:0] LastIdx = 8'(OamLen - 1);

    dma_state_e        state_q;
    logic [7:0]        page_q;
    logic [7:0]        idx_q;
    logic [7:0]        buf_q;
    logic              busy_q;
    logic              oam_we_q;
    logic [OAM_AW-1:0] oam_address_q;
    logic [7:0]        oam_data_q;
`ifdef C6502_DMA_DONE_EN
    logic              done_q;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            page_q        <= 8'h00;
            idx_q         <= 8'h00;
            buf_q         <= 8'h00;
            busy_q        <= 1'b0;
            oam_we_q      <= 1'b0;
            oam_address_q <= '0;
            oam_data_q    <= 8'h00;
`ifdef C6502_DMA_DONE_EN
            done_q        <= 1'b0;
`endif
        end else begin
            oam_we_q <= 1'b0;
`ifdef C6502_DMA_DONE_EN
            done_q   <= 1'b0;
`endif
            // Video owns the bus: every state freezes and no OAM write is issued.
            if (!hold_i) begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            page_q  <= start_page_i;
                            idx_q   <= 8'h00;
                            busy_q  <= 1'b1;
                            state_q <= StAlign;
                        end
                    end
                    StAlign: state_q <= StRd;
                    StRd: begin
                        buf_q   <= rd_data_i;
                        state_q <= StWr;
                    end
                    StWr: begin
                        oam_we_q      <= 1'b1;
                        oam_address_q <= OAM_AW'(idx_q);
                        oam_data_q    <= buf_q;
                        idx_q         <= idx_q + 8'd1;
                        if (idx_q == LastIdx) begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
`ifdef C6502_DMA_DONE_EN
                            done_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= StRd;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign busy_o        = busy_q;
    assign rd_address_o  = {page_q, idx_q};
    assign oam_address_o = oam_address_q;
    assign oam_data_o    = oam_data_q;
    assign oam_we_o      = oam_we_q;
`ifdef C6502_DMA_DONE_EN
    assign done_o        = done_q;
`endif

endmodule

// File: rtl/c6502_bus_arbiter.sv
// Main-memory arbiter for c6502: video > OAM DMA > CPU, CPU paced through cpu_ce_o.
// Defining C6502_DMA_DONE_EN adds the dma_done_o completion pulse.
module c6502_bus_arbiter
    import c6502_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG = DmaRegDefault,
    parameter int unsigned OAM_AW  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              cpu_ce_o,
    input  logic [15:0]       cpu_address_i,
    input  logic [7:0]        cpu_out_i,
    input  logic              cpu_we_i,
    output logic [7:0]        cpu_in_o,
    input  logic              vid_req_i,
    input  logic [15:0]       vid_address_i,
    output logic              vid_ack_o,
    output logic [7:0]        vid_data_o,
    output logic [15:0]       mem_address_o,
    input  logic [7:0]        mem_in_i,
    output logic [7:0]        mem_out_o,
    output logic              mem_we_o,
    output logic [OAM_AW-1:0] oam_address_o,
    output logic [7:0]        oam_data_o,
    output logic              oam_we_o,
    output logic              dma_busy_o
`ifdef C6502_DMA_DONE_EN
    ,
    output logic              dma_done_o
`endif
);

    logic        dma_busy;
    logic [15:0] dma_rd_address;
    logic        cpu_owns;
    logic        is_dma_reg;
    logic        dma_start;

    assign is_dma_reg = (cpu_address_i == DMA_REG);
    assign cpu_owns   = reset_n & ~vid_req_i & ~dma_busy;
    assign dma_start  = cpu_owns & cpu_we_i & is_dma_reg;

    always_comb begin
        mem_address_o = cpu_address_i;
        if (vid_req_i) begin
            mem_address_o = vid_address_i;
        end else if (dma_busy) begin
            mem_address_o = dma_rd_address;
        end
    end

    assign cpu_ce_o   = cpu_owns;
    assign vid_ack_o  = reset_n & vid_req_i;
    // The trigger register is write-only and never aliases into RAM.
    assign mem_we_o   = cpu_owns & cpu_we_i & ~is_dma_reg;
    assign mem_out_o  = cpu_out_i;
    assign cpu_in_o   = mem_in_i;
    assign vid_data_o = mem_in_i;
    assign dma_busy_o = dma_busy;

    c6502_oam_dma #(
        .OAM_AW (OAM_AW)
    ) u_oam_dma (
        .clock         (clock),
        .reset_n       (reset_n),
        .hold_i        (vid_req_i),
        .start_i       (dma_start),
        .start_page_i  (cpu_out_i),
        .rd_data_i     (mem_in_i),
        .busy_o        (dma_busy),
        .rd_address_o  (dma_rd_address),
        .oam_address_o (oam_address_o),
        .oam_data_o    (oam_data_o),
        .oam_we_o      (oam_we_o)
`ifdef C6502_DMA_DONE_EN
        ,
        .done_o        (dma_done_o)
`endif
    );

endmodule

// File: tb/tb_c6502_bus_arbiter.sv
// Randomized bench for c6502_bus_arbiter against a progress-counter model of the OAM copy.
module tb_c6502_bus_arbiter;

    logic        clock;
    logic        reset_n;
    logic        cpu_ce;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_we;
    logic [7:0]  cpu_in;
    logic        vid_req;
    logic [15:0] vid_address;
    logic        vid_ack;
    logic [7:0]  vid_data;
    logic [15:0] mem_address;
    logic [7:0]  mem_in;
    logic [7:0]  mem_out;
    logic        mem_we;
    logic [7:0]  oam_address;
    logic [7:0]  oam_data;
    logic        oam_we;
    logic        dma_busy;
    logic        dma_done;

    logic [7:0] ram     [0:65535];
    logic [7:0] oam_dut [0:255];
    logic [7:0] oam_exp [0:255];

    // Model: a copy is a progress count p = 0..512 advanced on every non-video cycle.
    // p = 0 is the dummy cycle, odd p reads byte (p-1)/2, even p > 0 writes that byte.
    bit         m_active;
    int         m_p;
    logic [7:0] m_page;
    logic [7:0] m_buf;
    bit         m_pend;
    logic [7:0] m_pend_addr;
    logic [7:0] m_pend_data;
    bit         m_done;

    int n_chk;
    int n_err;
    int busy_cnt;
    int done_cnt;
    logic last_ce;
    logic last_busy;
    logic last_mem_we;

    assign mem_in = ram[mem_address];

    c6502_bus_arbiter dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .cpu_ce_o      (cpu_ce),
        .cpu_address_i (cpu_address),
        .cpu_out_i     (cpu_out),
        .cpu_we_i      (cpu_we),
        .cpu_in_o      (cpu_in),
        .vid_req_i     (vid_req),
        .vid_address_i (vid_address),
        .vid_ack_o     (vid_ack),
        .vid_data_o    (vid_data),
        .mem_address_o (mem_address),
        .mem_in_i      (mem_in),
        .mem_out_o     (mem_out),
        .mem_we_o      (mem_we),
        .oam_address_o (oam_address),
        .oam_data_o    (oam_data),
        .oam_we_o      (oam_we),
        .dma_busy_o    (dma_busy)
`ifdef C6502_DMA_DONE_EN
        ,
        .dma_done_o    (dma_done)
`endif
    );

`ifndef C6502_DMA_DONE_EN
    assign dma_done = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] r16();
        return 16'($urandom());
    endfunction

    function automatic logic [7:0] r8();
        return 8'($urandom());
    endfunction

    function automatic logic [15:0] rnd_addr();
        logic [15:0] a;
        a = r16();
        if (a == 16'h4014) a = 16'h4015;
        return a;
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, then advance environment and model.
    task automatic step(input logic rst, input logic vr, input logic [15:0] va,
                        input logic [15:0] ca, input logic [7:0] co, input logic cw);
        logic        exp_ce;
        logic        exp_we;
        int          idx;
        logic        s_mem_we;
        logic        s_oam_we;
        logic [15:0] s_addr;
        logic [7:0]  s_out;
        logic [7:0]  s_oa;
        logic [7:0]  s_od;
        reset_n     = rst;
        vid_req     = vr;
        vid_address = va;
        cpu_address = ca;
        cpu_out     = co;
        cpu_we      = cw;
        #3;
        idx    = (m_p > 0) ? (m_p - 1) / 2 : 0;
        exp_ce = rst & ~vr & ~m_active;
        exp_we = exp_ce & cw & (ca != 16'h4014);
        chk("cpu_ce", 32'(cpu_ce), 32'(exp_ce));
        chk("vid_ack", 32'(vid_ack), 32'(rst & vr));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("dma_busy", 32'(dma_busy), 32'(m_active));
        chk("oam_we", 32'(oam_we), 32'(m_pend));
        if (m_pend) begin
            chk("oam_address", 32'(oam_address), 32'(m_pend_addr));
            chk("oam_data", 32'(oam_data), 32'(m_pend_data));
        end
        if (exp_we) chk("mem_out", 32'(mem_out), 32'(co));
        if (rst) begin
            if (vr) begin
                chk("vid_mem_address", 32'(mem_address), 32'(va));
                chk("vid_data", 32'(vid_data), 32'(ram[va]));
            end else if (!m_active) begin
                chk("cpu_mem_address", 32'(mem_address), 32'(ca));
                chk("cpu_in", 32'(cpu_in), 32'(ram[ca]));
            end else if (m_p % 2 == 1) begin
                chk("dma_rd_address", 32'(mem_address), 32'({m_page, 8'(idx)}));
            end
        end
`ifdef C6502_DMA_DONE_EN
        chk("dma_done", 32'(dma_done), 32'(m_done));
`endif
        if (dma_done) done_cnt++;
        if (dma_busy) busy_cnt++;
        last_ce     = cpu_ce;
        last_busy   = dma_busy;
        last_mem_we = mem_we;
        s_mem_we = mem_we;
        s_addr   = mem_address;
        s_out    = mem_out;
        s_oam_we = oam_we;
        s_oa     = oam_address;
        s_od     = oam_data;
        @(posedge clock);
        if (s_mem_we) ram[s_addr] = s_out;
        if (s_oam_we) oam_dut[s_oa] = s_od;
        if (!rst) begin
            m_active = 0;
            m_p      = 0;
            m_page   = 8'h00;
            m_buf    = 8'h00;
            m_pend   = 0;
            m_done   = 0;
        end else begin
            m_pend = 0;
            m_done = 0;
            if (!vr) begin
                if (m_active) begin
                    if (m_p % 2 == 1) begin
                        m_buf = ram[{m_page, 8'(idx)}];
                    end else if (m_p > 0) begin
                        m_pend      = 1;
                        m_pend_addr = 8'(idx);
                        m_pend_data = m_buf;
                        oam_exp[idx] = m_buf;
                    end
                    if (m_p == 512) begin
                        m_active = 0;
                        m_done   = 1;
                    end
                    m_p++;
                end else if (cw && ca == 16'h4014) begin
                    m_active = 1;
                    m_p      = 0;
                    m_page   = co;
                end
            end
        end
        #1;
    endtask

    task automatic idle_step();
        step(1'b1, 1'b0, r16(), rnd_addr(), r8(), 1'b0);
    endtask

    task automatic trigger(input logic [7:0] page);
        step(1'b1, 1'b0, r16(), 16'h4014, page, 1'b1);
    endtask

    task automatic run_until_idle(input int vid_pct);
        int  n;
        logic vr;
        n = 0;
        while (m_active && n < 3000) begin
            vr = ($urandom_range(99) < vid_pct);
            step(1'b1, vr, r16(), rnd_addr(), r8(), 1'($urandom()));
            n++;
        end
        chk("dma_finish_bound", 32'(m_active), 32'd0);
    endtask

    task automatic run_until_p(input int target);
        int n;
        n = 0;
        while (m_active && m_p != target && n < 2000) begin
            step(1'b1, 1'b0, r16(), rnd_addr(), r8(), 1'b0);
            n++;
        end
        chk("reach_progress", 32'(m_p), 32'(target));
    endtask

    task automatic oam_scan(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (oam_dut[i] !== oam_exp[i]) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        busy_cnt = 0;
        done_cnt = 0;
        m_active = 0;
        m_p      = 0;
        m_page   = 8'h00;
        m_buf    = 8'h00;
        m_pend   = 0;
        m_done   = 0;
        for (int i = 0; i < 65536; i++) ram[i] = r8();
        for (int i = 0; i < 256; i++) begin
            ram[16'h0200 + i] = 8'(i) ^ 8'h5A;
            oam_dut[i] = 8'h00;
            oam_exp[i] = 8'h00;
        end
        reset_n = 1'b0;
        vid_req = 1'b0;
        vid_address = 16'h0000;
        cpu_address = 16'h0000;
        cpu_out = 8'h00;
        cpu_we = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom()), r16(), rnd_addr(), r8(), 1'b1);
        idle_step();
        chk("ce_after_reset", 32'(last_ce), 32'd1);

        // Plain copy of page 2 without video contention.
        busy_cnt = 0;
        trigger(8'h02);
        chk("trigger_no_mem_we", 32'(last_mem_we), 32'd0);
        run_until_idle(0);
        chk("dma_len_513", 32'(busy_cnt), 32'd513);
        idle_step();
        chk("ce_after_dma", 32'(last_ce), 32'd1);
        chk("oam_exp_13", 32'(oam_exp[8'h13]), 32'h49);
        chk("oam_dut_13", 32'(oam_dut[8'h13]), 32'h49);
        oam_scan("oam_scan_page2");

        // Same copy with a 10-cycle video burst on the read of byte 0x40.
        busy_cnt = 0;
        trigger(8'h02);
        run_until_p(1 + 2 * 8'h40);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, r16(), rnd_addr(), r8(), 1'b0);
        run_until_idle(0);
        chk("dma_len_523", 32'(busy_cnt), 32'd523);
        idle_step();
        oam_scan("oam_scan_video");

        // CPU write deferred by video, then landing.
        ram[16'h0300] = 8'h00;
        step(1'b1, 1'b1, r16(), 16'h0300, 8'hAB, 1'b1);
        step(1'b1, 1'b1, r16(), 16'h0300, 8'hAB, 1'b1);
        chk("write_deferred", 32'(ram[16'h0300]), 32'h00);
        step(1'b1, 1'b0, r16(), 16'h0300, 8'hAB, 1'b1);
        chk("write_landed", 32'(ram[16'h0300]), 32'hAB);

        // Reset aborts a page-3 copy at byte 0x80.
        trigger(8'h03);
        run_until_p(1 + 2 * 8'h80);
        step(1'b0, 1'b0, r16(), rnd_addr(), r8(), 1'b0);
        idle_step();
        chk("ce_after_abort", 32'(last_ce), 32'd1);
        chk("busy_after_abort", 32'(last_busy), 32'd0);
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'($urandom_range(99) < 20), r16(), rnd_addr(), r8(), 1'($urandom()));
        chk("oam_90_untouched", 32'(oam_dut[8'h90]), 32'hCA);
        oam_scan("oam_scan_abort");

        // Back-to-back copies of page 2 then page 3.
        done_cnt = 0;
        trigger(8'h02);
        run_until_idle(0);
        trigger(8'h03);
        run_until_idle(25);
        idle_step();
        chk("oam_page3_byte0", 32'(oam_dut[0]), 32'(ram[16'h0300]));
        oam_scan("oam_scan_b2b");
`ifdef C6502_DMA_DONE_EN
        chk("done_pulses", 32'(done_cnt), 32'd2);
`endif

        // Mixed random traffic with occasional triggers and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) begin
                step(1'b1, 1'($urandom_range(99) < 10), r16(), 16'h4014, r8(), 1'b1);
            end else begin
                step(1'($urandom_range(999) != 0), 1'($urandom_range(99) < 20), r16(),
                     rnd_addr(), r8(), 1'($urandom()));
            end
        end
        run_until_idle(20);
        idle_step();
        oam_scan("oam_scan_random");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/c6502_bus_arbiter.md
Name: c6502_bus_arbiter

Overview:
Shares one main-memory port between the c6502 core, a video fetch port and a built-in page-copy DMA engine. The CPU is paced entirely through its ce input: it gets ce=1 only on cycles where it owns the bus.
A CPU write to a trigger address starts a 256-byte copy from a main-memory page into sprite/attribute RAM (OAM). The CPU is stalled for the whole copy.
Sits between c6502 and the board RAM / video generator.

Parameters:
DMA_REG, 16'h4014, CPU write address that triggers DMA; this write never reaches main memory.
OAM_AW, 8, OAM address width; the copy length is always 256 bytes.

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
cpu_ce  out  1  clock enable to c6502
cpu_address  in  16  c6502 address
cpu_out  in  8  c6502 write data
cpu_we  in  1  c6502 write strobe
cpu_in  out  8  read data to c6502
vid_req  in  1  video read request; one byte per cycle
vid_address  in  16  video read address
vid_ack  out  1  video granted this cycle; vid_data valid
vid_data  out  8  read data to video
mem_address  out  16  main RAM address
mem_in  in  8  main RAM read data; combinational, valid in the same cycle
mem_out  out  8  main RAM write data
mem_we  out  1  main RAM write enable
oam_address  out  OAM_AW  OAM write address
oam_data  out  8  OAM write data
oam_we  out  1  OAM write enable
dma_busy  out  1  DMA in progress

Behaviour:
- Bus ownership is decided fresh every cycle, by fixed priority:
  1. vid_req=1: video owns the bus. mem_address=vid_address, vid_ack=1, cpu_ce=0, DMA holds its state.
  2. Else DMA not IDLE: DMA owns the bus, cpu_ce=0.
  3. Else CPU owns the bus: cpu_ce=1, mem_address=cpu_address.
- Routing: mem_in goes combinationally to both cpu_in and vid_data.
- Write gating: mem_we = cpu_ce & cpu_we & (cpu_address != DMA_REG). mem_out = cpu_out.
- Trigger: a cycle with cpu_ce & cpu_we & cpu_address==DMA_REG latches page<=cpu_out and moves the FSM to ALIGN.
- DMA FSM states (encoded in the shared package):
  - IDLE: waiting for the trigger.
  - ALIGN: one dummy cycle, no memory access; then RD.
  - RD: mem_address={page,idx}; latch mem_in into a buffer; then WR.
  - WR: oam_we=1, oam_address=idx, oam_data=buffer; idx<=idx+1. If idx==255, return to IDLE, else go to RD.
- Video preemption: any DMA state (including WR) holds for the whole cycle while vid_req=1, and no oam_we is issued that cycle.
- DMA length: 1+512=513 cycles with no video contention; each video cycle adds one cycle.
- idx resets to 0 on every trigger; the 8-bit wrap at 255 ends the copy.
- dma_busy=1 in every state except IDLE.
- CPU read of DMA_REG returns mem_in (open bus); no side effect.
- Reset: cpu_ce=0, vid_ack=0, mem_we=0, oam_we=0, dma_busy=0, FSM=IDLE, idx=0, page=0, buffer=0.
  - Reset mid-DMA aborts the copy immediately; no further OAM writes.
  - On the first cycle after reset the CPU owns the bus (if vid_req=0).
- All outputs except cpu_in, vid_data, mem_address, mem_out, mem_we, cpu_ce and vid_ack are registered. Those listed are combinational from the current ownership decision.

Optional Feature:
C6502_DMA_DONE_EN
- Defined: adds output dma_done, a 1-cycle registered pulse in the cycle after the final WR (idx 255) completes.
- Undefined: the port and its logic are absent; completion is visible only as the dma_busy fall.

Decomposition:
- Package c6502_bus_pkg holds: DMA state enum (IDLE, ALIGN, RD, WR), DMA_REG default, OAM length constant 256.
- Sub-module c6502_oam_dma contains the FSM, page/idx/buffer registers and OAM outputs. Its interface:
  - in: hold (=vid_req), start, start_page.
  - out: busy, rd_address, oam_*.
- The top level keeps the priority mux and write gating.

Test Plan:
- CPU write 8'h02 to 16'h4014 with vid_req=0, RAM[16'h0200+i]=i^8'h5A → mem_we stays 0 on the trigger cycle; dma_busy high 513 cycles; OAM[i]=i^8'h5A for all 256 bytes; cpu_ce=0 throughout, 1 the next cycle.
- vid_req=1 for 10 cycles during DMA RD at idx=8'h40 → vid_ack=1 and vid_data=RAM[vid_address] each cycle; idx frozen; no oam_we; DMA total 523 cycles; OAM contents unchanged from the previous test.
- Plain CPU write 8'hAB to 16'h0300 → mem_we=1, mem_out=8'hAB for one cycle; with vid_req=1 that cycle → cpu_ce=0 and the write is deferred until vid_req drops.
- reset_n=0 for one cycle at idx=8'h80 → dma_busy=0, oam_we never asserted again; OAM[8'h80..8'hFF] untouched; cpu_ce=1 on the next cycle.
- Back-to-back triggers (page 8'h02 then 8'h03) → second copy starts with idx=0, overwrites OAM with the page-3 data; with C6502_DMA_DONE_EN, dma_done pulses exactly once per copy.
